// File: rtl/bamse_ioc.sv
// bamse_ioc: interrupt-on-change front end for the bamse PacoBlaze3 SoC.
//
// Each pushbutton input is synchronised (2 FFs) and debounced. Enabled
// rising/falling edges of the debounced levels latch pending flags, and
// any pending flag raises the PacoBlaze3 interrupt. Firmware reads and
// write-1-clears the flags over the port bus.
//
// Ports:
//   clk           system clock
//   rst           asynchronous reset, active-low
//   btn_in        raw button levels, active-high
//   port_id       port address; PORT_BASE+0..3 are decoded here
//   write_strobe  one-cycle write qualifier
//   read_strobe   one-cycle read qualifier (no side effects)
//   out_port      write data
//   in_port       read data, 0 when not addressed (OR-bus)
//   interrupt     interrupt request
//   interrupt_ack interrupt acknowledge pulse
//   btn_level     debounced levels
//   o_dbg_state   interrupt FSM state (0 IDLE, 1 REQ, 2 SERVICE)
//
// Register map (offset from PORT_BASE):
//   +0 LEVEL (RO)  +1 FLAGS (R/W1C, set wins)  +2 RISE_EN (RW)  +3 FALL_EN (RW)
//
// Interrupt handshake: interrupt is a level request that stays high
// from the cycle after the FSM sees a pending flag until the cycle after
// interrupt_ack is sampled high (or all flags were cleared first). After
// an ack the request is not raised again until FLAGS has read as zero,
// so flags arriving during the ISR are handled by the firmware re-reading
// FLAGS before RETURNI. An ack outside REQ is ignored.
`timescale 1ns/1ps
module bamse_ioc #(
  parameter int         N_IN            = 3,
  parameter int         DEBOUNCE_CYCLES = 32000,
  parameter logic [7:0] PORT_BASE       = 8'h10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] btn_in,
  input  logic [7:0]      port_id,
  input  logic            write_strobe,
  input  logic            read_strobe,
  input  logic [7:0]      out_port,
  output logic [7:0]      in_port,
  output logic            interrupt,
  input  logic            interrupt_ack,
  output logic [N_IN-1:0] btn_level,
  output logic [1:0]      o_dbg_state
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  logic [N_IN-1:0] r_sync1;
  logic [N_IN-1:0] r_sync2;
  logic [N_IN-1:0] r_stable;
  logic [N_IN-1:0] r_prev;
  logic [CW-1:0]   r_cnt [N_IN];
  logic [N_IN-1:0] r_flags;
  logic [N_IN-1:0] r_rise_en;
  logic [N_IN-1:0] r_fall_en;
  state_t          r_state;
  state_t          w_state_next;

  logic [7:0]      w_off;
  logic [N_IN-1:0] w_evt;
  logic [N_IN-1:0] w_clr;
  logic            w_pending;
  logic            w_unused;

  // read_strobe carries no side effects and out_port is wider than the
  // registers; fold them into one sink so every input bit has a reader.
  assign w_unused = ^{read_strobe, out_port};

  // Offset decode by subtraction so PORT_BASE need not be 4-aligned.
  assign w_off = port_id - PORT_BASE;

  // ---------------------------------------------------------------------
  // Input path: 2-FF synchroniser
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce: a level is accepted only after the synchronised input has
  // disagreed with the accepted level for DEBOUNCE_CYCLES consecutive
  // cycles. r_prev is the accepted level one cycle ago, for edge detect.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stable <= '0;
      r_prev   <= '0;
      for (int i = 0; i < N_IN; i++) r_cnt[i] <= '0;
    end else begin
      r_prev <= r_stable;
      for (int i = 0; i < N_IN; i++) begin
        if (r_sync2[i] != r_stable[i]) begin
          if (r_cnt[i] == CNT_LAST) begin
            r_stable[i] <= r_sync2[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign btn_level = r_stable;

  // ---------------------------------------------------------------------
  // Edge events, enables and flags
  // ---------------------------------------------------------------------
  assign w_evt = (r_stable & ~r_prev & r_rise_en) |
                 (~r_stable & r_prev & r_fall_en);

  assign w_clr = (write_strobe && (w_off == 8'd1)) ? out_port[N_IN-1:0] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_flags   <= '0;
    end else begin
      if (write_strobe && (w_off == 8'd2)) r_rise_en <= out_port[N_IN-1:0];
      if (write_strobe && (w_off == 8'd3)) r_fall_en <= out_port[N_IN-1:0];
      // Clear first, then OR in new events: a same-cycle set wins.
      r_flags <= (r_flags & ~w_clr) | w_evt;
    end
  end

  assign w_pending = |r_flags;

  // ---------------------------------------------------------------------
  // Read mux (combinational, zero when not addressed)
  // ---------------------------------------------------------------------
  always_comb begin
    in_port = '0;
    case (w_off)
      8'd0:    in_port[N_IN-1:0] = r_stable;
      8'd1:    in_port[N_IN-1:0] = r_flags;
      8'd2:    in_port[N_IN-1:0] = r_rise_en;
      8'd3:    in_port[N_IN-1:0] = r_fall_en;
      default: in_port = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Interrupt FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pending) w_state_next = S_REQ;
      end
      S_REQ: begin
        if (interrupt_ack)   w_state_next = S_SERVICE;
        else if (!w_pending) w_state_next = S_IDLE;
      end
      S_SERVICE: begin
        // Hold off re-raising until firmware has drained every flag.
        if (!w_pending) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign interrupt   = (r_state == S_REQ);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bamse_ioc.sv
`timescale 1ns/1ps
module tb_bamse_ioc;

  localparam int DEB = 4;

  // ---------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] btn_in = '0;
  logic [7:0] port_id = '0;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic [7:0] out_port = '0;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;
  logic [2:0] btn_level;
  logic [1:0] o_dbg_state;

  always #5 clk = ~clk;

  bamse_ioc #(
    .N_IN            (3),
    .DEBOUNCE_CYCLES (DEB),
    .PORT_BASE       (8'h10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .out_port      (out_port),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .btn_level     (btn_level),
    .o_dbg_state   (o_dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------
  // Reference model: button history -> accepted levels by run length,
  // flags as a set of pending bits, interrupt as a 3-phase protocol.
  // ---------------------------------------------------------------------
  logic [2:0] m_s1, m_s2;     // two-cycle delay line of btn_in
  logic [2:0] m_stable, m_prev;
  int         m_run [3];      // consecutive cycles of disagreement
  logic [2:0] m_flags, m_rise, m_fall;
  int         m_state;        // 0 idle, 1 requesting, 2 in service

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0;
    m_flags = '0; m_rise = '0; m_fall = '0; m_state = 0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
  endtask

  task automatic model_update();
    logic [2:0] evt, clr, nstab;
    logic [7:0] off;
    int         nst;
    if (!rst) begin
      model_reset();
      return;
    end
    off = port_id - 8'h10;
    evt = (m_stable & ~m_prev & m_rise) | (~m_stable & m_prev & m_fall);
    clr = (write_strobe && off == 8'd1) ? out_port[2:0] : 3'b000;
    nst = m_state;
    if (m_state == 0 && m_flags != 0) nst = 1;
    else if (m_state == 1 && interrupt_ack) nst = 2;
    else if (m_state != 0 && m_flags == 0) nst = 0;
    nstab = m_stable;
    for (int i = 0; i < 3; i++) begin
      if (m_s2[i] != m_stable[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] >= DEB) begin
          nstab[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (write_strobe && off == 8'd2) m_rise = out_port[2:0];
    if (write_strobe && off == 8'd3) m_fall = out_port[2:0];
    m_flags  = (m_flags & ~clr) | evt;
    m_prev   = m_stable;
    m_stable = nstab;
    m_s2     = m_s1;
    m_s1     = btn_in;
    m_state  = nst;
  endtask

  // ---------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [7:0] p, output logic [7:0] d);
    logic [7:0] save;
    save        = port_id;
    port_id     = p;
    read_strobe = 1'b1;
    #1;
    d           = in_port;
    read_strobe = 1'b0;
    port_id     = save;
  endtask

  task automatic check_all();
    logic [7:0] d;
    chk("level", {5'b0, btn_level}, {5'b0, m_stable});
    chk("irq",   {7'b0, interrupt}, {7'b0, (m_state == 1)});
    chk("state", {6'b0, o_dbg_state}, 8'(m_state));
    rd(8'h10, d); chk("rd_level", d, {5'b0, m_stable});
    rd(8'h11, d); chk("rd_flags", d, {5'b0, m_flags});
    rd(8'h12, d); chk("rd_rise",  d, {5'b0, m_rise});
    rd(8'h13, d); chk("rd_fall",  d, {5'b0, m_fall});
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    write_strobe  = 1'b0;
    interrupt_ack = 1'b0;
    check_all();
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    port_id      = p;
    out_port     = d;
    write_strobe = 1'b1;
    cycle();
    out_port     = '0;
  endtask

  task automatic rand_run(input int n);
    for (int c = 0; c < n; c++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(7, 0) == 0) btn_in[b] = ~btn_in[b];
      if ($urandom_range(9, 0) == 0) begin
        port_id      = ($urandom_range(4, 0) == 4) ? 8'h20 : 8'h10 + 8'($urandom_range(3, 0));
        out_port     = 8'($urandom);
        write_strobe = 1'b1;
      end
      if ($urandom_range(11, 0) == 0) interrupt_ack = 1'b1;
      cycle();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------
  // Directed + random sequence
  // ---------------------------------------------------------------------
  initial begin
    logic [7:0] d;
    logic       found;
    model_reset();

    // Reset held with buttons pressed and write strobes pulsing.
    for (int k = 0; k < 4; k++) begin
      btn_in       = 3'b111;
      port_id      = 8'h12;
      out_port     = 8'hFF;
      write_strobe = 1'b1;
      cycle();
      chk("rst_irq", {7'b0, interrupt}, 8'h00);
      chk("rst_level", {5'b0, btn_level}, 8'h00);
    end
    out_port = '0;
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      if (k == 5) chk("rel_level5", {5'b0, btn_level}, 8'h00);
      if (k == 6) chk("rel_level6", {5'b0, btn_level}, 8'h07);
    end
    rd(8'h11, d); chk("rel_flags", d, 8'h00);
    chk("rel_irq", {7'b0, interrupt}, 8'h00);

    // Debounce: release everything, then a short glitch, then a press.
    btn_in = 3'b000;
    repeat (8) cycle();
    wr(8'h12, 8'h01);
    btn_in[0] = 1'b1;
    repeat (3) cycle();
    btn_in[0] = 1'b0;
    repeat (8) cycle();
    rd(8'h11, d); chk("glitch_flags", d, 8'h00);
    chk("glitch_level", {7'b0, btn_level[0]}, 8'h00);
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (k == 5) chk("deb_level5", {7'b0, btn_level[0]}, 8'h00);
      if (k == 6) chk("deb_level6", {7'b0, btn_level[0]}, 8'h01);
      if (k == 7) begin rd(8'h11, d); chk("deb_flags7", d, 8'h01); end
      if (k == 8) chk("deb_irq8", {7'b0, interrupt}, 8'h01);
    end

    // Handshake.
    interrupt_ack = 1'b1;
    cycle();
    chk("ack_irq", {7'b0, interrupt}, 8'h00);
    repeat (3) cycle();
    chk("svc_irq", {7'b0, interrupt}, 8'h00);
    wr(8'h11, 8'h01);
    rd(8'h11, d); chk("w1c_flags", d, 8'h00);
    cycle();
    chk("idle_state", {6'b0, o_dbg_state}, 8'h00);
    chk("idle_irq", {7'b0, interrupt}, 8'h00);

    // Falling edge and masking.
    wr(8'h13, 8'h02);
    wr(8'h12, 8'h00);
    btn_in[1] = 1'b1;
    repeat (10) cycle();
    rd(8'h11, d); chk("press1_flags", d, 8'h00);
    btn_in[1] = 1'b0;
    repeat (10) cycle();
    rd(8'h11, d); chk("release1_flags", d, 8'h02);
    btn_in[2] = 1'b1;
    repeat (10) cycle();
    btn_in[2] = 1'b0;
    repeat (10) cycle();
    rd(8'h11, d); chk("mask2_flags", d, 8'h02);
    interrupt_ack = 1'b1;
    cycle();
    wr(8'h11, 8'h02);
    repeat (2) cycle();

    // Same-cycle set and clear: set wins.
    wr(8'h12, 8'h01);
    btn_in[0] = 1'b0;
    repeat (10) cycle();
    btn_in[0] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_stable[0] && !m_prev[0]) found = 1'b1;
      else cycle();
    end
    chk("simul_found", {7'b0, found}, 8'h01);
    wr(8'h11, 8'h01);
    rd(8'h11, d); chk("simul_flags", d, 8'h01);

    // Bus isolation.
    rd(8'h20, d); chk("iso_rd20", d, 8'h00);
    rd(8'h0F, d); chk("iso_rd0f", d, 8'h00);
    rd(8'h14, d); chk("iso_rd14", d, 8'h00);
    wr(8'h20, 8'hFF);
    rd(8'h12, d); chk("iso_rise", d, 8'h01);
    rd(8'h13, d); chk("iso_fall", d, 8'h02);
    rd(8'h11, d); chk("iso_flags", d, 8'h01);

    // Randomized traffic checked every cycle against the model.
    rand_run(1500);

    // Asynchronous reset mid-operation.
    #2;
    rst = 1'b0;
    #1;
    chk("async_irq", {7'b0, interrupt}, 8'h00);
    chk("async_level", {5'b0, btn_level}, 8'h00);
    rd(8'h11, d); chk("async_flags", d, 8'h00);
    cycle();
    rst = 1'b1;
    rand_run(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
